// File: rtl/mmio_pkg.sv
// ============================================================================
// Module   : mmio_pkg
// Brief    : Shared register offsets, bit indices and FIFO state encoding
//            for the memory-mapped store port.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mmio_pkg;

    // Register offsets from the window base address
    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] CTRL_OFS   = 32'h0000_0008;

    // STATUS bit positions
    localparam int FULL_B  = 0;
    localparam int EMPTY_B = 1;
    localparam int VALID_B = 2;
    localparam int OVF_B   = 3;
    localparam int CNT_LSB = 4;

    // CTRL bit positions
    localparam int EN_B    = 0;
    localparam int FLUSH_B = 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Power-of-two synchronous FIFO with flush and accept-when-full-
//            and-popping; occupancy tracked by an EMPTY/PARTIAL/FULL FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_full,
    output logic              o_empty,
    output logic [CW-1:0]     o_count,
    output logic [DATA_W-1:0] o_head,
    output logic              o_accept
);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    fifo_state_t       r_state;
    fifo_state_t       w_state_nxt;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_pop;
    logic              w_push;

    // Flush owns the cycle: it suppresses both the pop and any push
    assign w_pop    = i_pop && !i_flush && (r_state != ST_EMPTY);
    assign w_push   = i_push && !i_flush && ((r_state != ST_FULL) || w_pop);

    assign o_full   = (r_state == ST_FULL);
    assign o_empty  = (r_state == ST_EMPTY);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rd_ptr];
    assign o_accept = w_push;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = ST_PARTIAL;
                        w_count_nxt = r_count + CW'(1);
                    end
                end
                ST_PARTIAL: begin
                    if (w_push && !w_pop) begin
                        w_count_nxt = r_count + CW'(1);
                        w_state_nxt = (r_count == C_DEPTH - CW'(1)) ? ST_FULL : ST_PARTIAL;
                    end else if (w_pop && !w_push) begin
                        w_count_nxt = r_count - CW'(1);
                        w_state_nxt = (r_count == CW'(1)) ? ST_EMPTY : ST_PARTIAL;
                    end
                end
                ST_FULL: begin
                    if (w_pop && !w_push) begin
                        w_count_nxt = r_count - CW'(1);
                        w_state_nxt = ST_PARTIAL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_EMPTY;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (i_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Storage carries no reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/mmio_store_port.sv
// ============================================================================
// Module   : mmio_store_port
// Brief    : Core-bus store port: TXDATA stores queue into a FIFO drained
//            over valid/ready; STATUS/CTRL readable combinationally.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmio_store_port
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0080,
    parameter int          DEPTH     = 4,
    parameter int          DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              hit,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_sel_tx;
    logic          w_sel_status;
    logic          w_sel_ctrl;
    logic          w_push_req;
    logic          w_flush;
    logic          w_ovf_clr;
    logic          w_accept;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_status;
    logic          r_enable;
    logic          r_overflow;
    logic          w_unused;

    assign w_sel_tx     = (DataAdr == BASE_ADDR + TXDATA_OFS);
    assign w_sel_status = (DataAdr == BASE_ADDR + STATUS_OFS);
    assign w_sel_ctrl   = (DataAdr == BASE_ADDR + CTRL_OFS);
    assign hit          = w_sel_tx || w_sel_status || w_sel_ctrl;

    assign w_push_req   = MemWrite && w_sel_tx;
    assign w_flush      = MemWrite && w_sel_ctrl && WriteData[FLUSH_B];
    assign w_ovf_clr    = MemWrite && w_sel_status && WriteData[OVF_B];

    assign out_valid    = r_enable && !w_empty;

    // Upper store-data bits never reach the payload or any register field
    assign w_unused     = ^WriteData[31:DATA_W];

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_push_req),
        .i_data   (WriteData[DATA_W-1:0]),
        .i_pop    (out_valid && out_ready),
        .i_flush  (w_flush),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count),
        .o_head   (out_data),
        .o_accept (w_accept)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_enable   <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (MemWrite && w_sel_ctrl) r_enable <= WriteData[EN_B];
            // A dropped push outranks a same-cycle clear
            if (w_push_req && !w_accept) r_overflow <= 1'b1;
            else if (w_ovf_clr)          r_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[FULL_B]         = w_full;
        w_status[EMPTY_B]        = w_empty;
        w_status[VALID_B]        = out_valid;
        w_status[OVF_B]          = r_overflow;
        w_status[CNT_LSB +: CW]  = w_count;
    end

    always_comb begin
        ReadData = '0;
        if (w_sel_status)    ReadData = w_status;
        else if (w_sel_ctrl) ReadData[EN_B] = r_enable;
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_store_port.sv
// ============================================================================
// Module   : tb_mmio_store_port
// Brief    : Directed and random stimulus against a queue-based model of
//            the store port, with a stream scoreboard monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_store_port;

    localparam logic [31:0] B     = 32'h0000_0080;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        hit;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  m_q[$];
    logic [7:0]  q_exp[$];
    logic        m_en = 1'b1;
    logic        m_ovf = 1'b0;
    logic [31:0] s_rd;
    logic        s_hit;
    logic        s_valid;

    mmio_store_port #(
        .BASE_ADDR (B),
        .DEPTH     (DEPTH),
        .DATA_W    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .hit       (hit),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Stream scoreboard: every accepted handshake must match the oldest queued byte
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_unexpected got=%h exp=none", out_data);
                end else begin
                    e = q_exp.pop_front();
                    chk("stream_data", 32'(out_data), 32'(e));
                end
            end
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b0;
        MemWrite = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
        m_q.delete();
        q_exp.delete();
        m_en = 1'b1;
        m_ovf = 1'b0;
    endtask

    // One bus cycle: drive, check combinational outputs, then advance the model
    task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                        input logic rdy);
        int          sz;
        logic        valid, tx, fl, pop, push_ok, rej, ehit;
        logic [31:0] erd;
        MemWrite = mw; DataAdr = adr; WriteData = wd; out_ready = rdy;
        sz      = m_q.size();
        valid   = m_en && (sz != 0);
        tx      = mw && (adr == B);
        fl      = mw && (adr == B + 8) && wd[1];
        pop     = valid && rdy && !fl;
        push_ok = tx && ((sz < DEPTH) || pop);
        rej     = tx && !push_ok;
        ehit    = (adr == B) || (adr == B + 4) || (adr == B + 8);
        erd     = 32'h0;
        if (adr == B + 4)
            erd = 32'(sz) * 16 + (m_ovf ? 8 : 0) + (valid ? 4 : 0)
                + ((sz == 0) ? 2 : 0) + ((sz == DEPTH) ? 1 : 0);
        else if (adr == B + 8)
            erd = m_en ? 32'h1 : 32'h0;
        @(negedge clk);
        s_rd = ReadData; s_hit = hit; s_valid = out_valid;
        chk("out_valid", 32'(out_valid), 32'(valid));
        chk("hit", 32'(hit), 32'(ehit));
        chk("read_data", ReadData, erd);
        @(posedge clk);
        #1;
        if (fl) begin
            m_q.delete();
            q_exp.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push_ok) begin
                m_q.push_back(wd[7:0]);
                q_exp.push_back(wd[7:0]);
            end
        end
        if (rej) m_ovf = 1'b1;
        else if (mw && adr == B + 4 && wd[3]) m_ovf = 1'b0;
        if (mw && adr == B + 8) m_en = wd[0];
    endtask

    task automatic drain();
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("drain_empty", 32'(q_exp.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] adr, wd;
        logic        mw, rdy;
        int          r;

        // Reset then idle
        do_reset(2);
        step(1'b0, B + 4, 32'h0, 1'b0);
        chk("reset_status", s_rd, 32'h2);
        chk("reset_valid", 32'(s_valid), 32'h0);
        step(1'b0, B + 8, 32'h0, 1'b0);
        chk("reset_ctrl", s_rd, 32'h1);

        // Single byte, one-cycle latency, no bypass
        step(1'b1, B, 32'h0000_0119, 1'b1);
        chk("single_no_bypass", 32'(s_valid), 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("single_valid", 32'(s_valid), 32'h1);
        step(1'b0, B + 4, 32'h0, 1'b1);
        chk("single_after", s_rd, 32'h2);

        // Fill and overflow
        for (int i = 0; i < 5; i++) step(1'b1, B, 32'hA1 + 32'(i), 1'b0);
        step(1'b0, B + 4, 32'h0, 1'b0);
        chk("overflow_status", s_rd, 32'h4D);
        drain();
        step(1'b1, B + 4, 32'h8, 1'b0);
        step(1'b0, B + 4, 32'h0, 1'b0);
        chk("ovf_cleared", s_rd, 32'h2);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) step(1'b1, B, 32'hC1 + 32'(i), 1'b0);
        step(1'b1, B, 32'hB0, 1'b1);
        step(1'b0, B + 4, 32'h0, 1'b0);
        chk("full_pop_status", s_rd, 32'h45);
        drain();
        step(1'b0, B + 4, 32'h0, 1'b0);
        chk("full_pop_no_ovf", s_rd, 32'h2);

        // Disable and flush
        step(1'b1, B + 8, 32'h0, 1'b1);
        step(1'b1, B, 32'h11, 1'b1);
        step(1'b1, B, 32'h22, 1'b1);
        step(1'b0, B + 4, 32'h0, 1'b1);
        chk("disabled_status", s_rd, 32'h20);
        step(1'b1, B + 8, 32'h3, 1'b1);
        step(1'b0, B + 8, 32'h0, 1'b1);
        chk("flush_ctrl", s_rd, 32'h1);
        step(1'b0, B + 4, 32'h0, 1'b1);
        chk("flush_status", s_rd, 32'h2);

        // Reset mid-drain, then decode edges
        for (int i = 0; i < 3; i++) step(1'b1, B, 32'h50 + 32'(i), 1'b0);
        do_reset(1);
        step(1'b0, B + 4, 32'h0, 1'b0);
        chk("midreset_status", s_rd, 32'h2);
        step(1'b1, B + 2, 32'h77, 1'b1);
        chk("unaligned_hit", 32'(s_hit), 32'h0);
        step(1'b0, B + 4, 32'h0, 1'b1);
        chk("unaligned_nopush", s_rd, 32'h2);
        step(1'b0, B + 12, 32'h0, 1'b1);
        chk("beyond_rd", s_rd, 32'h0);
        chk("beyond_hit", 32'(s_hit), 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            r   = $urandom_range(0, 9);
            rdy = 1'($urandom_range(0, 1));
            mw  = 1'b0;
            adr = 32'h0;
            wd  = $urandom;
            case (r)
                0, 1, 2, 3, 4: begin mw = 1'b1; adr = B; end
                5: begin mw = 1'($urandom_range(0, 1)); adr = B + 4; end
                6: begin
                    mw  = 1'b1; adr = B + 8;
                    wd  = {30'h0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)};
                end
                7: adr = B + 8;
                8: begin mw = 1'($urandom_range(0, 1)); adr = B + 32'($urandom_range(0, 15)); end
                default: adr = $urandom;
            endcase
            if (mw && adr == B + 8 && wd[1]) rdy = 1'b0;
            step(mw, adr, wd, rdy);
        end
        step(1'b1, B + 8, 32'h1, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
